// File: rtl/alu_writeback_stage_pkg.sv
// Shared opcode encodings and default widths for the ALU writeback stage.
package alu_writeback_stage_pkg;
  localparam int WIDTH_DEF  = 8;
  localparam int DEST_W_DEF = 2;
  localparam int DEPTH_DEF  = 2;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SL   = 3'd1;
  localparam logic [2:0] OP_SR   = 3'd2;
  localparam logic [2:0] OP_AND  = 3'd3;
  localparam logic [2:0] OP_OR   = 3'd4;
  localparam logic [2:0] OP_XOR  = 3'd5;
  localparam logic [2:0] OP_NAND = 3'd6;
  localparam logic [2:0] OP_COMP = 3'd7;
endpackage

// File: rtl/alu_writeback_stage_if.sv
// ALU result inputs plus the upstream and writeback valid/ready channels.
interface alu_writeback_stage_if
  import alu_writeback_stage_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int DEST_W = DEST_W_DEF
);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        op;
  logic [DEST_W-1:0] dest;
  logic [WIDTH-1:0]  alu_add, alu_sl, alu_sr, alu_and;
  logic [WIDTH-1:0]  alu_or, alu_xor, alu_nand, alu_comp;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  out_data;
  logic [DEST_W-1:0] out_dest;
  logic              out_zero;
  logic              out_neg;
  logic [7:0]        retired;

  modport master (
    output in_valid, op, dest, alu_add, alu_sl, alu_sr, alu_and,
           alu_or, alu_xor, alu_nand, alu_comp, out_ready,
    input  in_ready, out_valid, out_data, out_dest, out_zero, out_neg, retired
  );

  modport slave (
    input  in_valid, op, dest, alu_add, alu_sl, alu_sr, alu_and,
           alu_or, alu_xor, alu_nand, alu_comp, out_ready,
    output in_ready, out_valid, out_data, out_dest, out_zero, out_neg, retired
  );
endinterface

// File: rtl/wb_skid_fifo.sv
// Generic DEPTH-entry valid/ready FIFO; when empty the output holds the last popped word.
module wb_skid_fifo #(
  parameter int W     = 12,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [W-1:0]  last;
  logic          push, pop;

  assign in_ready  = count < CW'(DEPTH);
  assign out_valid = count != '0;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign out_data  = out_valid ? mem[rd_ptr] : last;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      last   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        last   <= mem[rd_ptr];
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is not reset; count gates visibility, so stale words are never presented.
  always_ff @(posedge clk) begin
    if (!rst && push) mem[wr_ptr] <= in_data;
  end
endmodule

// File: rtl/alu_writeback_stage.sv
// Selects one ALU result by opcode, tags it with flags, and buffers it for register writeback.
module alu_writeback_stage
  import alu_writeback_stage_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int DEST_W = DEST_W_DEF
) (
  input logic                  clk,
  input logic                  rst,
  alu_writeback_stage_if.slave bus
);
  localparam int PW = WIDTH + DEST_W + 2;

  logic [WIDTH-1:0] sel;
  logic [PW-1:0]    entry, head;
  logic             zero, neg;

  // NOTE: default assignment first keeps this combinational block from inferring a latch.
  always_comb begin
    sel = '0;
    case (bus.op)
      OP_ADD:  sel = bus.alu_add;
      OP_SL:   sel = bus.alu_sl;
      OP_SR:   sel = bus.alu_sr;
      OP_AND:  sel = bus.alu_and;
      OP_OR:   sel = bus.alu_or;
      OP_XOR:  sel = bus.alu_xor;
      OP_NAND: sel = bus.alu_nand;
      OP_COMP: sel = bus.alu_comp;
      default: sel = '0;
    endcase
  end

  // Flags travel with the entry so the consumer sees them exactly as they were at push.
  assign zero  = sel == '0;
  assign neg   = sel[WIDTH-1];
  assign entry = {sel, bus.dest, zero, neg};

  wb_skid_fifo #(.W(PW), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .in_data   (entry),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .out_data  (head)
  );

  assign {bus.out_data, bus.out_dest, bus.out_zero, bus.out_neg} = head;

  always_ff @(posedge clk) begin
    if (rst)                              bus.retired <= '0;
    else if (bus.out_valid && bus.out_ready) bus.retired <= bus.retired + 8'd1;
  end
endmodule

// File: tb/tb_alu_writeback_stage.sv
// Scoreboard bench: the driver queues expected entries, a negedge monitor checks each handshake.
module tb_alu_writeback_stage;
  import alu_writeback_stage_pkg::*;

  typedef struct packed {
    logic [7:0] data;
    logic [1:0] dest;
    logic       zero;
    logic       neg;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] res [8];
  exp_t exp_q [$];
  int checks   = 0;
  int failures = 0;

  alu_writeback_stage_if #(.WIDTH(8), .DEST_W(2)) bus ();

  alu_writeback_stage #(.WIDTH(8), .DEPTH(2), .DEST_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  assign bus.alu_add  = res[0];
  assign bus.alu_sl   = res[1];
  assign bus.alu_sr   = res[2];
  assign bus.alu_and  = res[3];
  assign bus.alu_or   = res[4];
  assign bus.alu_xor  = res[5];
  assign bus.alu_nand = res[6];
  assign bus.alu_comp = res[7];

  task automatic expect_eq(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Offer one result; every non-selected ALU output carries a distinct background value.
  task automatic push(input logic [2:0] op_v, input logic [7:0] val, input logic [1:0] dest_v,
                      input logic z, input logic n);
    int waited = 0;
    for (int i = 0; i < 8; i++) res[i] = 8'hC0 + 8'(i);
    res[op_v]    = val;
    bus.op       = op_v;
    bus.dest     = dest_v;
    bus.in_valid = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.in_ready) begin
      expect_eq("push_timeout", 32'(bus.in_ready), 32'd1);
      bus.in_valid = 1'b0;
    end else begin
      exp_q.push_back(exp_t'{val, dest_v, z, n});
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int waited = 0;
    while (exp_q.size() != 0 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    expect_eq("drain_timeout", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin : monitor
    exp_t e, got;
    forever begin
      @(negedge clk);
      if (!rst && bus.out_valid && bus.out_ready) begin
        got = exp_t'{bus.out_data, bus.out_dest, bus.out_zero, bus.out_neg};
        if (exp_q.size() == 0) begin
          expect_eq("unexpected_output", 32'(got), 32'hFFFF);
        end else begin
          e = exp_q.pop_front();
          expect_eq("scoreboard", 32'(got), 32'(e));
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : driver
    logic [7:0] v;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.op        = 3'd0;
    bus.dest      = 2'd0;
    for (int i = 0; i < 8; i++) res[i] = 8'hC0 + 8'(i);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    expect_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
    expect_eq("rst_in_ready",  32'(bus.in_ready),  32'd1);
    expect_eq("rst_retired",   32'(bus.retired),   32'd0);
    expect_eq("rst_out_data",  32'(bus.out_data),  32'd0);
    expect_eq("rst_out_dest",  32'(bus.out_dest),  32'd0);
    expect_eq("rst_out_zero",  32'(bus.out_zero),  32'd0);
    expect_eq("rst_out_neg",   32'(bus.out_neg),   32'd0);

    // Single transaction: one-cycle latency, then retired becomes 1.
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    push(OP_ADD, 8'h3C, 2'd2, 1'b0, 1'b0);
    @(negedge clk);
    expect_eq("latency_valid", 32'(bus.out_valid), 32'd1);
    expect_eq("latency_data",  32'(bus.out_data),  32'h3C);
    @(negedge clk);
    expect_eq("retired_one", 32'(bus.retired), 32'd1);
    @(posedge clk); #1;

    // Every remaining opcode, including zero and negative flag cases.
    push(OP_SL,   8'h78, 2'd1, 1'b0, 1'b0);
    push(OP_SR,   8'h1E, 2'd3, 1'b0, 1'b0);
    push(OP_AND,  8'h00, 2'd0, 1'b1, 1'b0);
    push(OP_OR,   8'h7F, 2'd2, 1'b0, 1'b0);
    push(OP_XOR,  8'h81, 2'd1, 1'b0, 1'b1);
    push(OP_NAND, 8'hF0, 2'd3, 1'b0, 1'b1);
    push(OP_COMP, 8'h01, 2'd0, 1'b0, 1'b0);
    drain();
    @(negedge clk);
    expect_eq("retired_eight", 32'(bus.retired), 32'd8);
    @(posedge clk); #1;

    // Writeback stall: buffer fills, third result waits upstream.
    bus.out_ready = 1'b0;
    push(OP_OR,  8'h11, 2'd1, 1'b0, 1'b0);
    push(OP_XOR, 8'h22, 2'd2, 1'b0, 1'b0);
    @(negedge clk);
    expect_eq("full_in_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk); #1;
    fork
      push(OP_SL, 8'h33, 2'd3, 1'b0, 1'b0);
      begin
        repeat (3) begin
          @(negedge clk);
          expect_eq("stall_in_ready",  32'(bus.in_ready),  32'd0);
          expect_eq("stall_out_valid", 32'(bus.out_valid), 32'd1);
          expect_eq("stall_out_data",  32'(bus.out_data),  32'h11);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
      end
    join
    drain();
    @(negedge clk);
    expect_eq("retired_after_stall", 32'(bus.retired), 32'd11);
    @(posedge clk); #1;

    // Streaming at count==1: push and pop every cycle for 20 cycles.
    bus.out_ready = 1'b0;
    push(OP_AND, 8'h01, 2'd1, 1'b0, 1'b0);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      expect_eq("stream_out_valid", 32'(bus.out_valid), 32'd1);
      push(3'(i % 8), 8'h40 + 8'(i), 2'(i % 4), 1'b0, 1'b0);
    end
    bus.out_ready = 1'b0;
    @(negedge clk);
    expect_eq("stream_hold_valid", 32'(bus.out_valid), 32'd1);
    expect_eq("stream_retired",    32'(bus.retired),   32'd31);
    expect_eq("stream_in_ready",   32'(bus.in_ready),  32'd1);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    drain();

    // Reset with two entries buffered; inputs active during reset are ignored.
    bus.out_ready = 1'b0;
    push(OP_NAND, 8'hF0, 2'd3, 1'b0, 1'b1);
    push(OP_COMP, 8'h81, 2'd2, 1'b0, 1'b1);
    @(negedge clk);
    expect_eq("prerst_in_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.delete();
    bus.in_valid  = 1'b1;
    bus.op        = OP_ADD;
    res[0]        = 8'h77;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    rst           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    expect_eq("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    expect_eq("midrst_in_ready",  32'(bus.in_ready),  32'd1);
    expect_eq("midrst_retired",   32'(bus.retired),   32'd0);
    expect_eq("midrst_out_data",  32'(bus.out_data),  32'd0);
    expect_eq("midrst_out_dest",  32'(bus.out_dest),  32'd0);
    expect_eq("midrst_out_zero",  32'(bus.out_zero),  32'd0);
    expect_eq("midrst_out_neg",   32'(bus.out_neg),   32'd0);
    @(posedge clk); #1;

    // 256 pops from reset: retired reaches 255 then wraps to 0.
    bus.out_ready = 1'b1;
    for (int i = 0; i < 255; i++) begin
      v = 8'(i);
      push(3'(i % 8), v, 2'(i % 4), v == 8'h00, v[7]);
    end
    drain();
    @(negedge clk);
    expect_eq("retired_255", 32'(bus.retired), 32'd255);
    @(posedge clk); #1;
    push(OP_COMP, 8'hFF, 2'd3, 1'b0, 1'b1);
    drain();
    @(negedge clk);
    expect_eq("retired_wrap", 32'(bus.retired), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
